vga_text_renderer: RTL and testbench

- Consumes the timing outputs of the VGA timing generator (h_sync, v_sync, disp_ena, column, row) and produces 12-bit RGB pixels for the smart-home status screen.
- Renders an 80x30 text grid of 8x16 glyphs. Each cell carries its own foreground and background palette colour.
- Includes a character RAM with a write port for the controller, an auto-clear engine, and a blinking cursor.
- Sync and enable are delayed to stay aligned with the pixel pipeline.

---
 rtl/vga_text_pkg.sv | 48 ++++
 rtl/vga_font_rom.sv | 22 ++
 rtl/vga_text_renderer.sv | 201 ++++++++++++++++++++
 tb/tb_vga_text_renderer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_text_pkg.sv
// ============================================================================
// Module : vga_text_pkg
// Brief  : Cell format, geometry, palette and glyph image for the text renderer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package vga_text_pkg;

  typedef struct packed {
    logic [3:0] fg;
    logic [3:0] bg;
    logic [7:0] code;
  } cell_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  localparam int CELL_W    = 8;
  localparam int CELL_H    = 16;
  localparam int TEXT_COLS = 80;
  localparam int TEXT_ROWS = 30;
  localparam int NUM_CELLS = TEXT_COLS * TEXT_ROWS;
  localparam int PIPE_LAT  = 4;

  // Index 15 is the leftmost element.
  localparam logic [15:0][11:0] PALETTE = {
    12'hFFF, 12'hFF5, 12'hF5F, 12'hF55, 12'h5FF, 12'h5F5, 12'h55F, 12'h555,
    12'hAAA, 12'hA50, 12'hA0A, 12'hA00, 12'h0AA, 12'h0A0, 12'h00A, 12'h000
  };

  // Glyph image: NUL and space are blank, top and bottom lines are blank,
  // other lines are the code XORed with the replicated line number.
  function automatic logic [7:0] font_glyph(input logic [11:0] addr);
    logic [7:0] code;
    logic [3:0] line;
    code = addr[11:4];
    line = addr[3:0];
    if (code == 8'h00 || code == 8'h20 || line == 4'd0 || line == 4'd15)
      return 8'h00;
    return code ^ {line, line};
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_font_rom.sv
// ============================================================================
// Module : vga_font_rom
// Brief  : 4096x8 glyph ROM, address {char code, glyph line}, registered read.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module vga_font_rom
  import vga_text_pkg::*;
(
  input  logic        clk_i,
  input  logic [11:0] addr_i,
  output logic [7:0]  data_o
);

  always_ff @(posedge clk_i) begin
    data_o <= font_glyph(addr_i);
  end

endmodule

`default_nettype wire

// File: rtl/vga_text_renderer.sv
// ============================================================================
// Module : vga_text_renderer
// Brief  : 80x30 text-mode pixel pipeline with char RAM, clear engine, cursor.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module vga_text_renderer
  import vga_text_pkg::*;
#(
  parameter int          COLS         = 80,
  parameter int          ROWS         = 30,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [15:0] CLEAR_WORD   = 16'h7020,
  parameter logic        H_POL        = 1'b0,
  parameter logic        V_POL        = 1'b0
) (
  input  logic        pixel_clk,
  input  logic        reset_n,
  input  logic        h_sync_in,
  input  logic        v_sync_in,
  input  logic        disp_ena_in,
  input  logic [9:0]  column,
  input  logic [9:0]  row,
  input  logic        wr_en,
  input  logic [11:0] wr_addr,
  input  logic [15:0] wr_data,
  input  logic        clr,
  output logic        busy,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_x,
  input  logic [4:0]  cursor_y,
  output logic        h_sync,
  output logic        v_sync,
  output logic        disp_ena,
  output logic [11:0] rgb
);

  localparam int          NCELLS    = COLS * ROWS;
  localparam int          BW        = $clog2(BLINK_FRAMES + 1);
  localparam logic [11:0] LAST_ADDR = 12'(NCELLS - 1);

  clr_state_e  state_q, state_d;
  logic [11:0] clr_addr_q, clr_addr_d;

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == ST_IDLE) begin
      if (clr) begin
        state_d    = ST_CLEAR;
        clr_addr_d = '0;
      end
    end else if (clr_addr_q == LAST_ADDR) begin
      state_d    = ST_IDLE;
      clr_addr_d = '0;
    end else begin
      clr_addr_d = clr_addr_q + 12'd1;
    end
  end

  assign busy = (state_q == ST_CLEAR);

  // The clear engine owns the write port; controller writes are dropped.
  logic        w_we;
  logic [11:0] w_waddr;
  cell_t       w_wdata;

  always_comb begin
    w_we    = 1'b0;
    w_waddr = wr_addr;
    w_wdata = cell_t'(wr_data);
    if (busy) begin
      w_we    = 1'b1;
      w_waddr = clr_addr_q;
      w_wdata = cell_t'(CLEAR_WORD);
    end else if (wr_en && (wr_addr < 12'(NCELLS))) begin
      w_we = 1'b1;
    end
  end

  logic          vs_prev_q;
  logic [BW-1:0] blink_cnt_q;
  logic          blink_q;
  logic          w_frame;

  assign w_frame = (v_sync_in == V_POL) && (vs_prev_q != V_POL);

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_prev_q   <= ~V_POL;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      vs_prev_q <= v_sync_in;
      if (w_frame) begin
        if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt_q <= '0;
          blink_q     <= ~blink_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + 1'b1;
        end
      end
    end
  end

  logic [11:0] w_cell_addr;
  logic        w_cursor;

  assign w_cell_addr = 12'(int'(row[9:4]) * COLS + int'(column[9:3]));
  assign w_cursor    = cursor_en && blink_q && (column[9:3] == cursor_x) &&
                       (row[9:4] == {1'b0, cursor_y}) && (row[3:1] == 3'b111);

  logic [11:0] s0_addr_q;
  logic [3:0]  s0_line_q, s1_line_q;
  logic [2:0]  s0_bit_q, s1_bit_q, s2_bit_q;
  logic        s0_cur_q, s1_cur_q, s2_cur_q;
  logic [2:0]  s0_sync_q, s1_sync_q, s2_sync_q, s3_sync_q;  // {hs, vs, en}
  logic [3:0]  s2_fg_q, s2_bg_q;
  logic [11:0] s3_rgb_q;
  cell_t       s1_cell_q;
  logic [7:0]  w_glyph;

  cell_t ram [NCELLS];

  // Read-first: the registered read sees the contents before this edge's write.
  always_ff @(posedge pixel_clk) begin
    if (w_we) ram[w_waddr] <= w_wdata;
    s1_cell_q <= (s0_addr_q < 12'(NCELLS)) ? ram[s0_addr_q] : cell_t'('0);
  end

  vga_font_rom u_font (
    .clk_i  (pixel_clk),
    .addr_i ({s1_cell_q.code, s1_line_q}),
    .data_o (w_glyph)
  );

  logic       w_pix;
  logic [3:0] w_idx;

  assign w_pix = w_glyph[3'd7 - s2_bit_q];
  assign w_idx = (w_pix ^ s2_cur_q) ? s2_fg_q : s2_bg_q;

  localparam logic [2:0] SYNC_IDLE = {~H_POL, ~V_POL, 1'b0};

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      s0_addr_q <= '0;
      s0_line_q <= '0;
      s0_bit_q  <= '0;
      s0_cur_q  <= 1'b0;
      s0_sync_q <= SYNC_IDLE;
      s1_line_q <= '0;
      s1_bit_q  <= '0;
      s1_cur_q  <= 1'b0;
      s1_sync_q <= SYNC_IDLE;
      s2_bit_q  <= '0;
      s2_cur_q  <= 1'b0;
      s2_fg_q   <= '0;
      s2_bg_q   <= '0;
      s2_sync_q <= SYNC_IDLE;
      s3_sync_q <= SYNC_IDLE;
      s3_rgb_q  <= '0;
    end else begin
      s0_addr_q <= w_cell_addr;
      s0_line_q <= row[3:0];
      s0_bit_q  <= column[2:0];
      s0_cur_q  <= w_cursor;
      s0_sync_q <= {h_sync_in, v_sync_in, disp_ena_in};
      s1_line_q <= s0_line_q;
      s1_bit_q  <= s0_bit_q;
      s1_cur_q  <= s0_cur_q;
      s1_sync_q <= s0_sync_q;
      s2_bit_q  <= s1_bit_q;
      s2_cur_q  <= s1_cur_q;
      s2_fg_q   <= s1_cell_q.fg;
      s2_bg_q   <= s1_cell_q.bg;
      s2_sync_q <= s1_sync_q;
      s3_sync_q <= s2_sync_q;
      s3_rgb_q  <= s2_sync_q[0] ? PALETTE[w_idx] : 12'h000;
    end
  end

  assign h_sync   = s3_sync_q[2];
  assign v_sync   = s3_sync_q[1];
  assign disp_ena = s3_sync_q[0];
  assign rgb      = s3_rgb_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_text_renderer.sv
// ============================================================================
// Module : tb_vga_text_renderer
// Brief  : Scoreboard bench for vga_text_renderer; driver queues, monitor pops.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_vga_text_renderer;
  import vga_text_pkg::*;

  logic        pixel_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        h_sync_in = 1'b1, v_sync_in = 1'b1, disp_ena_in = 1'b0;
  logic [9:0]  column = '0, row = '0;
  logic        wr_en = 1'b0;
  logic [11:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        clr = 1'b0;
  logic        busy;
  logic        cursor_en = 1'b0;
  logic [6:0]  cursor_x = '0;
  logic [4:0]  cursor_y = '0;
  logic        h_sync, v_sync, disp_ena;
  logic [11:0] rgb;

  vga_text_renderer dut (
    .pixel_clk(pixel_clk), .reset_n(reset_n),
    .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .disp_ena_in(disp_ena_in),
    .column(column), .row(row),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr(clr), .busy(busy),
    .cursor_en(cursor_en), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .h_sync(h_sync), .v_sync(v_sync), .disp_ena(disp_ena), .rgb(rgb)
  );

  always #5 pixel_clk = ~pixel_clk;

  int cyc = 0;
  always @(posedge pixel_clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    int          tag;
    int          col;
    int          row;
    logic [14:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  logic [15:0] mem_m [2400];
  logic [7:0]  a_glyph [16] = '{8'h00, 8'h50, 8'h63, 8'h72, 8'h05, 8'h14, 8'h27, 8'h36,
                                8'hC9, 8'hD8, 8'hEB, 8'hFA, 8'h8D, 8'h9C, 8'hAF, 8'h00};
  int   frames = 0;
  logic phase = 1'b0;
  logic prev_vs = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [11:0] pal(input logic [3:0] i);
    case (i)
      4'd0:    return 12'h000;
      4'd1:    return 12'h00A;
      4'd7:    return 12'hAAA;
      4'd15:   return 12'hFFF;
      default: return 12'hxxx;
    endcase
  endfunction

  function automatic logic [11:0] model_rgb(input int col, input int rw, input logic en);
    int          a;
    logic [15:0] c;
    logic [7:0]  g;
    logic [3:0]  ln, fi, bi, t;
    logic        b, cur;
    if (!en) return 12'h000;
    a   = (rw / 16) * 80 + col / 8;
    c   = mem_m[a];
    ln  = 4'(rw % 16);
    g   = (c[7:0] == 8'h41) ? a_glyph[ln] : 8'h00;
    b   = g[7 - (col % 8)];
    cur = cursor_en && (col / 8 == int'(cursor_x)) && (rw / 16 == int'(cursor_y)) &&
          (ln >= 4'd14) && phase;
    fi  = c[15:12];
    bi  = c[11:8];
    if (cur) begin t = fi; fi = bi; bi = t; end
    return pal(b ? fi : bi);
  endfunction

  task automatic drive(input logic hs, input logic vs, input logic en, input int col, input int rw);
    exp_t e;
    @(posedge pixel_clk); #1;
    h_sync_in   = hs;
    v_sync_in   = vs;
    disp_ena_in = en;
    column      = 10'(col);
    row         = 10'(rw);
    e.tag = cyc + PIPE_LAT;
    e.col = col;
    e.row = rw;
    e.val = {hs, vs, en, model_rgb(col, rw, en)};
    sb.push_back(e);
    if (prev_vs && !vs) begin
      if (frames == 29) begin frames = 0; phase = ~phase; end
      else frames++;
    end
    prev_vs = vs;
  endtask

  task automatic write_cell(input int addr, input logic [15:0] data);
    @(posedge pixel_clk); #1;
    wr_en = 1'b1; wr_addr = 12'(addr); wr_data = data;
    @(posedge pixel_clk); #1;
    wr_en = 1'b0;
    if (addr < 2400) mem_m[addr] = data;
  endtask

  task automatic pulse_clr();
    @(posedge pixel_clk); #1; clr = 1'b1;
    @(posedge pixel_clk); #1; clr = 1'b0;
  endtask

  // Counts cycles with busy high; optionally injects a clr+write mid-clear.
  task automatic wait_busy(input int inj_at, input int rst_at, output int cnt);
    cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge pixel_clk);
      if (!busy) return;
      cnt++;
      if (cnt == inj_at) begin
        clr = 1'b1; wr_en = 1'b1; wr_addr = 12'd5; wr_data = 16'hF141;
      end
      if (cnt == inj_at + 1) begin clr = 1'b0; wr_en = 1'b0; end
      if (cnt == rst_at) return;
    end
    n_total++;
    $display("FAIL busy_timeout: busy still high after %0d cycles, required low", cnt);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2400; i++) mem_m[i] = 16'h7020;
  endtask

  always @(negedge pixel_clk) begin
    while (sb.size() > 0 && sb[0].tag < cyc) begin
      mon_e = sb.pop_front();
      n_total++;
      $display("FAIL pix_missed(%0d,%0d): output never sampled, required %h",
               mon_e.col, mon_e.row, mon_e.val);
    end
    if (sb.size() > 0 && sb[0].tag == cyc) begin
      mon_e = sb.pop_front();
      check($sformatf("pix(%0d,%0d){hs,vs,en,rgb}", mon_e.col, mon_e.row),
            32'({h_sync, v_sync, disp_ena, rgb}), 32'(mon_e.val));
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  logic [4:0] sweep [12] = '{5'b11100, 5'b01100, 5'b01000, 5'b10000, 5'b10100, 5'b11100,
                             5'b00100, 5'b11000, 5'b01100, 5'b11100, 5'b11100, 5'b11000};
  int sweep_c [12] = '{1, 3, 1, 2, 0, 7, 4, 5, 6, 8, 2, 0};
  int sweep_r [12] = '{1, 1, 1, 2, 2, 3, 4, 5, 6, 1, 8, 0};

  initial begin
    int cnt;
    logic [4:0] v;
    model_clear();

    repeat (3) @(posedge pixel_clk);
    @(negedge pixel_clk);
    check("reset_outputs{hs,vs,en,rgb}", 32'({h_sync, v_sync, disp_ena, rgb}), 32'({3'b110, 12'h000}));
    check("reset_busy", 32'(busy), 32'd1);

    @(posedge pixel_clk); #1; reset_n = 1'b1;
    wait_busy(0, 0, cnt);
    check("init_clear_cycles", cnt, 2400);

    drive(1, 1, 1, 0, 0);
    drive(1, 1, 1, 13, 37);
    drive(1, 1, 1, 320, 240);
    drive(1, 1, 1, 639, 479);

    write_cell(0, 16'hF141);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 8; c++)
        drive(1, 1, 1, c, r);

    for (int i = 0; i < 12; i++) begin
      v = sweep[i];
      drive(v[4], v[3], v[2], sweep_c[i], sweep_r[i]);
    end

    cursor_x = 7'd79; cursor_y = 5'd29; cursor_en = 1'b1;
    for (int f = 0; f < 60; f++) begin
      drive(1, 0, 0, 0, 0);
      drive(1, 1, 0, 0, 0);
      drive(1, 1, 1, 632, 478);
      drive(1, 1, 1, 639, 479);
      drive(1, 1, 1, 635, 477);
    end
    cursor_en = 1'b0;
    repeat (6) @(posedge pixel_clk);

    drive(1, 1, 1, 320, 100);
    pulse_clr();
    wait_busy(100, 0, cnt);
    check("clr_cycles_ignoring_reclr", cnt, 2400);
    model_clear();
    drive(1, 1, 1, 41, 1);
    drive(1, 1, 1, 43, 3);
    drive(1, 1, 1, 1, 1);

    write_cell(2400, 16'hF141);
    drive(1, 1, 1, 1, 1);
    drive(1, 1, 1, 633, 465);
    write_cell(2399, 16'h1141);
    drive(1, 1, 1, 632, 465);
    for (int i = 0; i < 5; i++) drive(0, 1, 1, 632, 465);
    repeat (6) @(posedge pixel_clk);

    pulse_clr();
    wait_busy(0, 1000, cnt);
    #2;
    check("pre_reset{hs,en,rgb}", 32'({h_sync, disp_ena, rgb}), 32'({2'b01, 12'h00A}));
    reset_n = 1'b0;
    #1;
    check("async_reset{hs,vs,en,rgb}", 32'({h_sync, v_sync, disp_ena, rgb}), 32'({3'b110, 12'h000}));
    check("async_reset_busy", 32'(busy), 32'd1);
    h_sync_in = 1'b1; v_sync_in = 1'b1; disp_ena_in = 1'b0;
    frames = 0; phase = 1'b0; prev_vs = 1'b1;
    model_clear();
    repeat (2) @(posedge pixel_clk);
    #1; reset_n = 1'b1;
    wait_busy(0, 0, cnt);
    check("restart_clear_cycles", cnt, 2400);
    drive(1, 1, 1, 632, 465);
    drive(1, 1, 1, 0, 0);

    repeat (8) @(posedge pixel_clk);
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_total++;
      $display("FAIL pix_pending(%0d,%0d): never checked, required %h", mon_e.col, mon_e.row, mon_e.val);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
